// File: rtl/hazard_unit_if.sv
// Decode-side hazard/forwarding bundle shared by decode and the hazard unit.
// The master end is decode: it presents the instruction fields and consumes the
// forwarding selects and stall/flush controls.
interface hazard_unit_if #(
  parameter int unsigned REG_ADDR_W = 5
);

  // Decode instruction fields
  logic [REG_ADDR_W-1:0] rs_d;
  logic [REG_ADDR_W-1:0] rt_d;
  logic                  uses_rs_d;
  logic                  uses_rt_d;
  logic                  reg_write_d;
  logic                  mem_to_reg_d;
  logic [REG_ADDR_W-1:0] write_reg_d;
  logic                  branch_taken_d;
  logic                  jump_d;
  logic                  muldiv_start_d;
  logic                  hilo_read_d;

  // Hazard controls back to the pipeline
  logic [1:0]            sel_a_d;
  logic [1:0]            sel_b_d;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic                  muldiv_busy;

  modport master (
    output rs_d,
    output rt_d,
    output uses_rs_d,
    output uses_rt_d,
    output reg_write_d,
    output mem_to_reg_d,
    output write_reg_d,
    output branch_taken_d,
    output jump_d,
    output muldiv_start_d,
    output hilo_read_d,
    input  sel_a_d,
    input  sel_b_d,
    input  stall_f,
    input  stall_d,
    input  flush_d,
    input  flush_e,
    input  muldiv_busy
  );

  modport slave (
    input  rs_d,
    input  rt_d,
    input  uses_rs_d,
    input  uses_rt_d,
    input  reg_write_d,
    input  mem_to_reg_d,
    input  write_reg_d,
    input  branch_taken_d,
    input  jump_d,
    input  muldiv_start_d,
    input  hilo_read_d,
    output sel_a_d,
    output sel_b_d,
    output stall_f,
    output stall_d,
    output flush_d,
    output flush_e,
    output muldiv_busy
  );

endinterface

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage core.
// Shadows the destination register of the instructions in E, M and W, and the
// hi/lo multiply/divide occupancy, so decode can pick forwarded operands and the
// pipeline knows when to stall, squash or bubble.
module hazard_unit #(
  parameter int unsigned MULDIV_LATENCY = 4,
  parameter int unsigned REG_ADDR_W     = 5
) (
  input  logic         clock,
  input  logic         reset,
  hazard_unit_if.slave hz
);

  localparam int unsigned CntW = $clog2(MULDIV_LATENCY + 1);

  // Forwarding select encoding
  localparam logic [1:0] SelRegFile = 2'd0;
  localparam logic [1:0] SelAluE    = 2'd1;
  localparam logic [1:0] SelAluM    = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] write_reg;
  } entry_t;

  localparam entry_t EntryEmpty = '{
    valid:      1'b0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    write_reg:  '0
  };

  // Tracking state
  entry_t          e_q, e_d;
  entry_t          m_q, m_d;
  entry_t          w_q, w_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Hazard terms
  logic match_e_rs, match_e_rt;
  logic match_m_rs, match_m_rt;
  logic load_stall;
  logic hilo_stall;
  logic stall;
  logic busy;

  // Register 0 is hard-wired, so a write to it never produces a hazard.
  function automatic logic entry_match(entry_t ent, logic [REG_ADDR_W-1:0] r);
    return ent.valid & ent.reg_write & (ent.write_reg == r) & (r != '0);
  endfunction

  // Destination-register matches against E and M for both decode sources.
  always_comb begin
    match_e_rs = hz.uses_rs_d & entry_match(e_q, hz.rs_d);
    match_e_rt = hz.uses_rt_d & entry_match(e_q, hz.rt_d);
    match_m_rs = hz.uses_rs_d & entry_match(m_q, hz.rs_d);
    match_m_rt = hz.uses_rt_d & entry_match(m_q, hz.rt_d);
  end

  // Stall decision: load data is only available from W, so a load in E or M
  // holds decode; a busy hi/lo unit holds any new mult/div or hi/lo read.
  always_comb begin
    load_stall = ((match_e_rs | match_e_rt) & e_q.mem_to_reg) |
                 ((match_m_rs | match_m_rt) & m_q.mem_to_reg);
    busy       = (cnt_q != '0);
    hilo_stall = busy & (hz.muldiv_start_d | hz.hilo_read_d);
    stall      = load_stall | hilo_stall;
  end

  // Forwarding selects, E has priority over M; W needs no forward because the
  // register file writes before it reads.
  always_comb begin
    hz.sel_a_d = SelRegFile;
    hz.sel_b_d = SelRegFile;
    if (match_e_rs && !e_q.mem_to_reg) begin
      hz.sel_a_d = SelAluE;
    end else if (match_m_rs && !m_q.mem_to_reg) begin
      hz.sel_a_d = SelAluM;
    end
    if (match_e_rt && !e_q.mem_to_reg) begin
      hz.sel_b_d = SelAluE;
    end else if (match_m_rt && !m_q.mem_to_reg) begin
      hz.sel_b_d = SelAluM;
    end
  end

  // Pipeline control outputs. A stalled branch may be comparing stale operands,
  // so its flush waits until the stall clears.
  always_comb begin
    hz.stall_f     = stall;
    hz.stall_d     = stall;
    hz.flush_e     = stall;
    hz.flush_d     = (hz.branch_taken_d | hz.jump_d) & ~stall;
    hz.muldiv_busy = busy;
  end

  // Next state: M and W keep draining during a stall, E takes a bubble.
  always_comb begin
    w_d = m_q;
    m_d = e_q;
    e_d = EntryEmpty;
    if (!stall) begin
      e_d.valid      = 1'b1;
      e_d.reg_write  = hz.reg_write_d;
      e_d.mem_to_reg = hz.mem_to_reg_d;
      e_d.write_reg  = hz.write_reg_d;
    end

    cnt_d = cnt_q;
    if (hz.muldiv_start_d && !stall) begin
      cnt_d = CntW'(MULDIV_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      e_q   <= EntryEmpty;
      m_q   <= EntryEmpty;
      w_q   <= EntryEmpty;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  // W is tracked for completeness of the pipeline shadow but needs no action.
  logic unused_w;
  assign unused_w = ^w_q;

endmodule
